// File: rtl/debounce_sched_pkg.sv
// Shared types for the debounce scheduler: scan-state encoding and the event record
// (channel, level) handed to consumers.
package debounce_sched_pkg;

  localparam int MAX_CH   = 16;
  localparam int MAX_CH_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic                level;
  } event_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: returns the first requesting index strictly after i_last,
// wrapping, so the channel granted last has the lowest priority next time.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_gnt,
  output logic         o_gnt_vld
);

  logic [W-1:0] cand;

  // Walk from farthest to nearest so the closest requester after i_last wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_gnt     = '0;
    o_gnt_vld = 1'b0;
    cand      = '0;
    for (int i = N; i >= 1; i--) begin
      cand = W'((int'(i_last) + i) % N);
      if (i_req[cand]) begin
        o_gnt     = cand;
        o_gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Time-multiplexed button debouncer: one shared prescaler and a per-tick scan over all
// channels. Define DEBOUNCE_EVENTS_EN to build the event queue, arbiter and handshake.
module debounce_scheduler
  import debounce_sched_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int TICK_DIV       = 1000,
  parameter int DEBOUNCE_LIMIT = 20
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic [NUM_CH-1:0]         i_Bouncy,
  output logic [NUM_CH-1:0]         o_Debounced,
  output logic                      o_Event_Valid,
  input  logic                      i_Event_Ready,
  output logic [$clog2(NUM_CH)-1:0] o_Event_Ch,
  output logic                      o_Event_Level,
  output logic                      o_Overflow
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int CNT_W   = $clog2(DEBOUNCE_LIMIT);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [NUM_CH-1:0]  sync1_q, sync2_q;
  logic [PRESC_W-1:0] presc_q, presc_d;
  scan_state_e        state_q, state_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CH];
  logic [CNT_W-1:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0]  deb_q, deb_d;
  logic               flip;

  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (presc_q == PRESC_LAST) begin
          state_d = SCAN;
          ptr_d   = '0;
        end
      end
      SCAN: begin
        if (ptr_q == CH_LAST) state_d = IDLE;
        else                  ptr_d   = ptr_q + CH_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the channel under the scan pointer may touch its counter or state.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    flip  = 1'b0;
    if (state_q == SCAN) begin
      if (sync2_q[ptr_q] != deb_q[ptr_q]) begin
        if (cnt_q[ptr_q] == CNT_LAST) begin
          flip          = 1'b1;
          deb_d[ptr_q]  = ~deb_q[ptr_q];
          cnt_d[ptr_q]  = '0;
        end else begin
          cnt_d[ptr_q]  = cnt_q[ptr_q] + CNT_W'(1);
        end
      end else begin
        cnt_d[ptr_q] = '0;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      state_q <= IDLE;
      ptr_q   <= '0;
      deb_q   <= '0;
      // NOTE: the counter array is reset explicitly; a mid-count reset must discard progress.
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= i_Bouncy;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Debounced = deb_q;

`ifdef DEBOUNCE_EVENTS_EN
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] lvl_q, lvl_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]   ev_ch_q, ev_ch_d;
  logic              ev_lvl_q, ev_lvl_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_vld;
  logic              load, take;

  rr_arbiter #(.N(NUM_CH), .W(CH_W)) u_arb (
    .i_req     (pend_q),
    .i_last    (last_q),
    .o_gnt     (gnt_idx),
    .o_gnt_vld (gnt_vld)
  );

  // A flip on the channel being granted this cycle re-arms it with the new level.
  always_comb begin
    pend_d   = pend_q;
    lvl_d    = lvl_q;
    last_d   = last_q;
    ev_ch_d  = ev_ch_q;
    ev_lvl_d = ev_lvl_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    load     = !valid_q || i_Event_Ready;
    take     = load && gnt_vld;
    if (load) begin
      valid_d = gnt_vld;
      if (gnt_vld) begin
        ev_ch_d         = gnt_idx;
        ev_lvl_d        = lvl_q[gnt_idx];
        last_d          = gnt_idx;
        pend_d[gnt_idx] = 1'b0;
      end
    end
    if (flip) begin
      if (pend_q[ptr_q] && !(take && gnt_idx == ptr_q)) ovf_d = 1'b1;
      pend_d[ptr_q] = 1'b1;
      lvl_d[ptr_q]  = ~deb_q[ptr_q];
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pend_q   <= '0;
      lvl_q    <= '0;
      last_q   <= CH_LAST;
      ev_ch_q  <= '0;
      ev_lvl_q <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      lvl_q    <= lvl_d;
      last_q   <= last_d;
      ev_ch_q  <= ev_ch_d;
      ev_lvl_q <= ev_lvl_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_Event_Valid = valid_q;
  assign o_Event_Ch    = ev_ch_q;
  assign o_Event_Level = ev_lvl_q;
  assign o_Overflow    = ovf_q;
`else
  logic unused_evt;
  assign unused_evt    = ^{i_Event_Ready, flip};
  assign o_Event_Valid = 1'b0;
  assign o_Event_Ch    = '0;
  assign o_Event_Level = 1'b0;
  assign o_Overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler (NUM_CH=4, TICK_DIV=8, DEBOUNCE_LIMIT=4); event
// expectations collapse to zero when DEBOUNCE_EVENTS_EN is not defined.
module tb_debounce_scheduler;

`ifdef DEBOUNCE_EVENTS_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] bouncy;
  logic [3:0] debounced;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_ch;
  logic       ev_level;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  debounce_scheduler #(
    .NUM_CH         (4),
    .TICK_DIV       (8),
    .DEBOUNCE_LIMIT (4)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Bouncy      (bouncy),
    .o_Debounced   (debounced),
    .o_Event_Valid (ev_valid),
    .i_Event_Ready (ev_ready),
    .o_Event_Ch    (ev_ch),
    .o_Event_Level (ev_level),
    .o_Overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ev(input logic [31:0] v);
    return EV ? v : 32'd0;
  endfunction

  // Cycle numbering: posedge N after reset release; checks land on the following negedge.
  task automatic go(input int p);
    while (cyc < p) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_deb"},   32'(debounced), 32'd0);
    check({tag, "_valid"}, 32'(ev_valid),  32'd0);
    check({tag, "_ch"},    32'(ev_ch),     32'd0);
    check({tag, "_lvl"},   32'(ev_level),  32'd0);
    check({tag, "_ovf"},   32'(overflow),  32'd0);
  endtask

  // Assert reset with all buttons pressed, hold it, then release with pattern b.
  task automatic reset_dut(input logic [3:0] b);
    @(negedge clk);
    bouncy = 4'b1111;
    rst    = 1'b1;
    #1;
    outputs_zero("rst_now");
    @(negedge clk);
    @(negedge clk);
    outputs_zero("rst_held");
    rst    = 1'b0;
    bouncy = b;
    cyc    = 0;
  endtask

  initial begin
    rst      = 1'b0;
    bouncy   = 4'b0000;
    ev_ready = 1'b0;

    // Single press on channel 1: visits at 10,18,26,34.
    reset_dut(4'b0010);
    go(33); check("p1_deb_before", 32'(debounced), 32'h0);
    go(34); check("p1_deb_flip",   32'(debounced), 32'h2);
            check("p1_valid_lat",  32'(ev_valid),  32'd0);
    go(35); check("p1_valid",      32'(ev_valid),  ev(1));
            check("p1_ch",         32'(ev_ch),     ev(1));
            check("p1_lvl",        32'(ev_level),  ev(1));
            check("p1_ovf",        32'(overflow),  32'd0);
    go(40); check("p1_hold_valid", 32'(ev_valid),  ev(1));
            check("p1_hold_ch",    32'(ev_ch),     ev(1));

    // Reset with an event held: nothing survives.
    reset_dut(4'b0000);
    go(20); check("p1_discard_valid", 32'(ev_valid),  32'd0);
            check("p1_discard_deb",   32'(debounced), 32'h0);

    // Channel 2 high for three visits (11,19,27) then low before 35.
    reset_dut(4'b0100);
    go(27); check("glitch_deb_mid", 32'(debounced), 32'h0);
    go(30); bouncy = 4'b0000;
    go(60); check("glitch_deb",     32'(debounced), 32'h0);
            check("glitch_valid",   32'(ev_valid),  32'd0);

    // Channels 0 and 2 in one scan (flips at 33 and 35), drained in order.
    reset_dut(4'b0101);
    go(33); check("two_deb0",   32'(debounced), 32'h1);
    go(34); check("two_valid0", 32'(ev_valid),  ev(1));
            check("two_ch0",    32'(ev_ch),     ev(0));
            check("two_lvl0",   32'(ev_level),  ev(1));
    go(35); check("two_deb02",  32'(debounced), 32'h5);
    go(36); check("two_hold",   32'(ev_ch),     ev(0));
            ev_ready = 1'b1;
    go(37); check("two_valid2", 32'(ev_valid),  ev(1));
            check("two_ch2",    32'(ev_ch),     ev(2));
            check("two_lvl2",   32'(ev_level),  ev(1));
    go(38); check("two_drop",   32'(ev_valid),  32'd0);
            ev_ready = 1'b0;

    // Channel 0 occupies the output; channel 3 press (36) then release (68) overwrites.
    reset_dut(4'b1001);
    go(34); check("ovf_valid0",   32'(ev_valid),  ev(1));
            check("ovf_ch0",      32'(ev_ch),     ev(0));
    go(36); check("ovf_press",    32'(debounced), 32'h9);
            bouncy = 4'b0001;
    go(67); check("ovf_before",   32'(overflow),  32'd0);
    go(68); check("ovf_release",  32'(debounced), 32'h1);
            check("ovf_set",      32'(overflow),  ev(1));
            check("ovf_held_ch",  32'(ev_ch),     ev(0));
            ev_ready = 1'b1;
    go(69); check("ovf_valid3",   32'(ev_valid),  ev(1));
            check("ovf_ch3",      32'(ev_ch),     ev(3));
            check("ovf_lvl3",     32'(ev_level),  ev(0));
    go(70); check("ovf_drop",     32'(ev_valid),  32'd0);
    go(80); check("ovf_sticky",   32'(overflow),  ev(1));
            ev_ready = 1'b0;

    // Reset after three mismatching visits of channel 0 restarts the count.
    reset_dut(4'b0001);
    go(25); check("midrst_before", 32'(debounced), 32'h0);
    reset_dut(4'b0001);
    go(32); check("midrst_nofl",   32'(debounced), 32'h0);
    go(33); check("midrst_flip",   32'(debounced), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
